// File: rtl/idu_addr_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : idu_addr_if
// Purpose : Bus-side signals of the increment/decrement unit and address
//           latch. The oam_bug signal exists only with IDU_OAM_BUG_EN defined.
// Revision: 1.0 - initial release
// ============================================================================
interface idu_addr_if;
    logic [7:0]  abus;
    logic [7:0]  cbus;
    logic [7:0]  dbus;
    logic        sel_ab;
    logic        sel_cd;
    logic        ld_addr;
    logic        inc;
    logic        dec;
    logic        stall;
    logic [15:0] A;
    logic [7:0]  adl;
    logic [7:0]  adh;
    logic        res_valid;
    logic        idu_cy;
    logic        sel_err;
`ifdef IDU_OAM_BUG_EN
    logic        oam_bug;

    modport master (
        output abus, cbus, dbus, sel_ab, sel_cd, ld_addr, inc, dec, stall,
        input  A, adl, adh, res_valid, idu_cy, sel_err, oam_bug
    );
    modport slave (
        input  abus, cbus, dbus, sel_ab, sel_cd, ld_addr, inc, dec, stall,
        output A, adl, adh, res_valid, idu_cy, sel_err, oam_bug
    );
`else
    modport master (
        output abus, cbus, dbus, sel_ab, sel_cd, ld_addr, inc, dec, stall,
        input  A, adl, adh, res_valid, idu_cy, sel_err
    );
    modport slave (
        input  abus, cbus, dbus, sel_ab, sel_cd, ld_addr, inc, dec, stall,
        output A, adl, adh, res_valid, idu_cy, sel_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/idu_addr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : idu_addr
// Purpose : Two-stage increment/decrement unit with external address latch.
//           Optional OAM corruption flag under macro IDU_OAM_BUG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module idu_addr #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  wire logic   CLK,
    input  wire logic   SYNC_RES,
    idu_addr_if.slave   bus
);

    logic [15:0] a_q,         a_d;
    logic [15:0] res_q,       res_d;
    logic [1:0]  op_q,        op_d;
    logic        v1_q,        v1_d;
    logic        res_valid_q, res_valid_d;
    logic        idu_cy_q,    idu_cy_d;
    logic        sel_err_q,   sel_err_d;
`ifdef IDU_OAM_BUG_EN
    logic        oam_bug_q,   oam_bug_d;
`endif

    logic [7:0]  w_lo;
    logic        w_inc_only;
    logic        w_dec_only;
    logic [15:0] w_sum;
    logic        w_cy;
    logic        w_illegal;

    // Buses carry complemented data; a double select is the wired-AND of both.
    always_comb begin
        w_lo = 8'h00;
        if (bus.sel_ab && bus.sel_cd)
            w_lo = ~(bus.abus & bus.cbus);
        else if (bus.sel_ab)
            w_lo = ~bus.abus;
        else if (bus.sel_cd)
            w_lo = ~bus.cbus;
    end

    assign w_inc_only = (op_q == 2'b10);
    assign w_dec_only = (op_q == 2'b01);
    assign w_sum      = w_inc_only ? (a_q + 16'd1) :
                        w_dec_only ? (a_q - 16'd1) : a_q;
    assign w_cy       = (w_inc_only && (a_q == 16'hFFFF)) ||
                        (w_dec_only && (a_q == 16'h0000));
    assign w_illegal  = (bus.sel_ab && bus.sel_cd) || (bus.inc && bus.dec);

    always_comb begin
        a_d         = a_q;
        res_d       = res_q;
        op_d        = op_q;
        v1_d        = v1_q;
        res_valid_d = 1'b0;
        idu_cy_d    = idu_cy_q;
        sel_err_d   = sel_err_q;
`ifdef IDU_OAM_BUG_EN
        oam_bug_d   = 1'b0;
`endif
        if (!bus.stall) begin
            idu_cy_d = 1'b0;
            v1_d     = bus.ld_addr;
            if (bus.ld_addr) begin
                a_d  = {~bus.dbus, w_lo};
                op_d = {bus.inc, bus.dec};
                if (w_illegal)
                    sel_err_d = 1'b1;
            end
            // Stage 2 works from the address captured on the previous edge.
            if (v1_q) begin
                res_d       = w_sum;
                res_valid_d = 1'b1;
                idu_cy_d    = w_cy;
`ifdef IDU_OAM_BUG_EN
                oam_bug_d   = (w_inc_only || w_dec_only) && (a_q[15:8] == 8'hFE);
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            a_q         <= RESET_ADDR;
            res_q       <= RESET_ADDR;
            op_q        <= 2'b00;
            v1_q        <= 1'b0;
            res_valid_q <= 1'b0;
            idu_cy_q    <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef IDU_OAM_BUG_EN
            oam_bug_q   <= 1'b0;
`endif
        end else begin
            a_q         <= a_d;
            res_q       <= res_d;
            op_q        <= op_d;
            v1_q        <= v1_d;
            res_valid_q <= res_valid_d;
            idu_cy_q    <= idu_cy_d;
            sel_err_q   <= sel_err_d;
`ifdef IDU_OAM_BUG_EN
            oam_bug_q   <= oam_bug_d;
`endif
        end
    end

    assign bus.A         = a_q;
    assign bus.adl       = res_q[7:0];
    assign bus.adh       = res_q[15:8];
    assign bus.res_valid = res_valid_q;
    assign bus.idu_cy    = idu_cy_q;
    assign bus.sel_err   = sel_err_q;
`ifdef IDU_OAM_BUG_EN
    assign bus.oam_bug   = oam_bug_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idu_addr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_idu_addr
// Purpose : Scoreboard bench for idu_addr (address latch and IDU result).
// Revision: 1.0 - initial release
// ============================================================================
module tb_idu_addr;

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        oam;
    } exp_t;

    logic CLK;
    logic SYNC_RES;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    idu_addr_if bus ();

    idu_addr #(.RESET_ADDR(16'h0000)) dut (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .bus      (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result monitor: every res_valid pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (!SYNC_RES && bus.res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rv", {31'd0, bus.res_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", {16'd0, bus.adh, bus.adl}, {16'd0, e.res});
                chk("idu_cy", {31'd0, bus.idu_cy}, {31'd0, e.cy});
`ifdef IDU_OAM_BUG_EN
                chk("oam_bug", {31'd0, bus.oam_bug}, {31'd0, e.oam});
`endif
            end
        end
    end

    task automatic idle(input int n);
        bus.ld_addr = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ld(input logic [7:0] ab, input logic [7:0] cb, input logic [7:0] db,
                      input bit sa, input bit sc, input bit i, input bit d);
        logic [7:0]  lo;
        logic [15:0] addr;
        exp_t        e;
        lo = 8'h00;
        if (sa && sc)  lo = ~(ab & cb);
        else if (sa)   lo = ~ab;
        else if (sc)   lo = ~cb;
        addr  = {~db, lo};
        e.res = addr;
        e.cy  = 1'b0;
        e.oam = 1'b0;
        if (i && !d) begin
            e.res = addr + 16'd1;
            e.cy  = (addr == 16'hFFFF);
            e.oam = (addr[15:8] == 8'hFE);
        end else if (d && !i) begin
            e.res = addr - 16'd1;
            e.cy  = (addr == 16'h0000);
            e.oam = (addr[15:8] == 8'hFE);
        end
        exp_q.push_back(e);
        bus.abus = ab; bus.cbus = cb; bus.dbus = db;
        bus.sel_ab = sa; bus.sel_cd = sc; bus.inc = i; bus.dec = d;
        bus.ld_addr = 1'b1;
        @(posedge CLK);
        #1;
        chk("A_latch", {16'd0, bus.A}, {16'd0, addr});
        bus.ld_addr = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.abus = 8'hFF; bus.cbus = 8'hFF; bus.dbus = 8'hFF;
        bus.sel_ab = 0; bus.sel_cd = 0; bus.ld_addr = 0;
        bus.inc = 0; bus.dec = 0; bus.stall = 0;
        SYNC_RES = 1'b1;
        repeat (2) @(posedge CLK);
        #1 SYNC_RES = 1'b0;
        idle(3);
        chk("rst_A",   {16'd0, bus.A}, 32'h0000);
        chk("rst_res", {16'd0, bus.adh, bus.adl}, 32'h0000);
        chk("rst_rv",  {31'd0, bus.res_valid}, 32'd0);
        chk("rst_err", {31'd0, bus.sel_err}, 32'd0);
        chk("rst_cy",  {31'd0, bus.idu_cy}, 32'd0);

        // Basic increment and latency
        ld(~8'h34, 8'h00, ~8'h12, 1, 0, 1, 0);
        chk("rv_before", {31'd0, bus.res_valid}, 32'd0);
        idle(1);
        chk("rv_lat2", {31'd0, bus.res_valid}, 32'd1);
        idle(1);
        chk("rv_pulse", {31'd0, bus.res_valid}, 32'd0);

        // Wrap both ways
        ld(8'h00, ~8'hFF, ~8'hFF, 0, 1, 1, 0);
        idle(2);
        ld(~8'h00, 8'h00, ~8'h00, 1, 0, 0, 1);
        idle(2);

        // Back-to-back stream
        ld(~8'h00, 8'h00, ~8'hC0, 1, 0, 1, 0);
        ld(~8'h01, 8'h00, ~8'hC0, 1, 0, 1, 0);
        chk("b2b_rv1", {31'd0, bus.res_valid}, 32'd1);
        ld(~8'h02, 8'h00, ~8'hC0, 1, 0, 1, 0);
        chk("b2b_rv2", {31'd0, bus.res_valid}, 32'd1);
        idle(1);
        chk("b2b_rv3", {31'd0, bus.res_valid}, 32'd1);
        idle(1);
        chk("b2b_end", {31'd0, bus.res_valid}, 32'd0);

        // Stall holds the in-flight operation
        ld(~8'h00, 8'h00, ~8'h80, 1, 0, 0, 1);
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            #1;
            chk("stall_rv", {31'd0, bus.res_valid}, 32'd0);
        end
        bus.stall = 1'b0;
        @(posedge CLK);
        #1;
        chk("stall_resume", {31'd0, bus.res_valid}, 32'd1);
        chk("stall_A", {16'd0, bus.A}, 32'h8000);
        idle(2);

        // Reset during stall discards the operation
        ld(~8'h55, 8'h00, ~8'h80, 1, 0, 0, 1);
        bus.stall = 1'b1;
        @(posedge CLK);
        SYNC_RES = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        chk("sr_A",   {16'd0, bus.A}, 32'h0000);
        chk("sr_res", {16'd0, bus.adh, bus.adl}, 32'h0000);
        chk("sr_rv",  {31'd0, bus.res_valid}, 32'd0);
        SYNC_RES = 1'b0;
        bus.stall = 1'b0;
        idle(1);
        chk("sr_rv_after", {31'd0, bus.res_valid}, 32'd0);
        idle(1);
        chk("sr_rv_after2", {31'd0, bus.res_valid}, 32'd0);

        // Double select: wired-AND low byte, sticky error
        ld(~8'hF0, ~8'h0F, ~8'hAB, 1, 1, 0, 0);
        chk("dsel_lo", {24'd0, bus.A[7:0]}, 32'h00FF);
        idle(2);
        chk("dsel_err", {31'd0, bus.sel_err}, 32'd1);
        ld(8'h00, 8'h00, ~8'hFF, 0, 0, 0, 1);
        idle(2);
        chk("err_sticky", {31'd0, bus.sel_err}, 32'd1);

        // inc & dec: pass-through plus error
        SYNC_RES = 1'b1;
        @(posedge CLK);
        #1 SYNC_RES = 1'b0;
        chk("err_cleared", {31'd0, bus.sel_err}, 32'd0);
        ld(~8'h10, 8'h00, ~8'h20, 1, 0, 1, 1);
        idle(2);
        chk("incdec_err", {31'd0, bus.sel_err}, 32'd1);

`ifdef IDU_OAM_BUG_EN
        ld(~8'h10, 8'h00, ~8'hFE, 1, 0, 1, 0);
        idle(2);
        ld(~8'h10, 8'h00, ~8'hFD, 1, 0, 1, 0);
        idle(2);
        ld(~8'h20, 8'h00, ~8'hFE, 1, 0, 0, 1);
        idle(2);
`endif

        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
